// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if
//  Bundles the serial line and the receive-side result signals of the UART
//  receiver so the controller and its environment connect through one port.
//
//  Signals
//   rx_in           serial line into the receiver, idles high
//   rx_data_out     last received byte, bit0 = first data bit on the line
//   rx_valid_out    one-cycle strobe: rx_data_out and the error flags are new
//   parity_err_out  parity mismatch on the last frame (qualified by rx_valid_out)
//   frame_err_out   stop bit sampled low on the last frame (qualified by rx_valid_out)
//   rx_busy_out     receiver is inside a frame (start detected, not yet idle)
//   state_dbg       current receiver FSM state encoding, for observation only
//
//  Handshake: rx_valid_out is a valid-only strobe with no ready/back-pressure.
//  It is high for exactly one Clk cycle per received frame, and the consumer
//  must capture rx_data_out/parity_err_out/frame_err_out in that cycle. The
//  data and flags then hold their value until the next strobe.
//
//  Modports
//   master  line driver / host side: drives rx_in, observes the results
//   slave   the receiver: samples rx_in, drives the results
interface uart_rx_fsm_if;
  logic       rx_in;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       parity_err_out;
  logic       frame_err_out;
  logic       rx_busy_out;
  logic [2:0] state_dbg;

  modport master (
    output rx_in,
    input  rx_data_out,
    input  rx_valid_out,
    input  parity_err_out,
    input  frame_err_out,
    input  rx_busy_out,
    input  state_dbg
  );

  modport slave (
    input  rx_in,
    output rx_data_out,
    output rx_valid_out,
    output parity_err_out,
    output frame_err_out,
    output rx_busy_out,
    output state_dbg
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//  UART receive controller. Oversamples the serial line and recovers one frame:
//  start(0), 8 data bits LSB-first, parity, stop(1). Each frame is reported with
//  a one-cycle valid strobe together with parity and framing error flags, even
//  when an error is flagged.
//
//  Parameters
//   CLKS_PER_BIT  Clk cycles per bit period (even, >= 4)
//   PARITY_ODD    0 = even parity (parity bit = ^data), 1 = odd parity
//
//  Ports
//   Clk    system clock, all logic on posedge
//   reset  synchronous, active-high; aborts any frame in progress
//   bus    uart_rx_fsm_if.slave: rx_in in; rx_data_out, rx_valid_out,
//          parity_err_out, frame_err_out, rx_busy_out, state_dbg out
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic          Clk,
  input logic          reset,
  uart_rx_fsm_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_m, rx_s, rx_p;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          perr_q, perr_d;
  logic          load_out;
  logic          bit_end;

  logic [7:0]    data_q;
  logic          valid_q;
  logic          perr_out_q;
  logic          ferr_out_q;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Only a high-to-low transition starts a frame, so a line held low
        // (break) cannot retrigger until it has risen again.
        if (rx_p && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          // Line back high at mid start bit: treat as a glitch, drop quietly.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = rx_s ^ (^sh_q) ^ PARITY_ODD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          load_out = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_p       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      sh_q       <= 8'h00;
      perr_q     <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      rx_m    <= bus.rx_in;
      rx_s    <= rx_m;
      rx_p    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      valid_q <= load_out;
      if (load_out) begin
        data_q     <= sh_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ~rx_s;
      end
    end
  end

  assign bus.rx_data_out    = data_q;
  assign bus.rx_valid_out   = valid_q;
  assign bus.parity_err_out = perr_out_q;
  assign bus.frame_err_out  = ferr_out_q;
  assign bus.rx_busy_out    = (state_q != IDLE);
  assign bus.state_dbg      = state_q;

endmodule
